// File: rtl/mult_div_seq.sv
// mult_div_seq: sequencer for MULT/DIV; Booth radix-2 multiply or restoring divide, one step per clock, into HI/LO.
// Define MULT_DIV_UNSIGNED_EN to add op_unsigned for MULTU/DIVU.
module mult_div_seq #(
    parameter int W = 32,
    parameter int CNT_W = 6
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start_mult,
    input  logic         start_div,
`ifdef MULT_DIV_UNSIGNED_EN
    input  logic         op_unsigned,
`endif
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    output logic         busy,
    output logic         done,
    output logic         div_zero,
    output logic [W-1:0] hi_out,
    output logic [W-1:0] lo_out
);
    localparam logic [1:0] IDLE = 2'd0, RUN_M = 2'd1, RUN_D = 2'd2, FIN = 2'd3;
    logic [1:0] state;
    logic [CNT_W-1:0] count;
    logic [2*W+1:0] prod;
    logic [W:0] mcand, boothSum, remShift;
    logic [W-1:0] rem, quo, dvsr, trialDiff, absA, absB;
    logic unsignedOp, fixMsb, negQuo, negRem, opDiv, divByZero, trialFits, lastStep;
`ifdef MULT_DIV_UNSIGNED_EN
    assign unsignedOp = op_unsigned;
`else
    assign unsignedOp = 1'b0;
`endif
    assign busy = state == RUN_M || state == RUN_D;
    assign lastStep = count == CNT_W'(W - 1);
    // Accumulator upper half carries one guard bit so a zero-extended multiplicand never overflows.
    always_comb begin
        absA = !unsignedOp && op_a[W-1] ? -op_a : op_a;
        absB = !unsignedOp && op_b[W-1] ? -op_b : op_b;
        boothSum = prod[1:0] == 2'b01 ? prod[2*W+1:W+1] + mcand :
                   prod[1:0] == 2'b10 ? prod[2*W+1:W+1] - mcand : prod[2*W+1:W+1];
        remShift = {rem, quo[W-1]};
        trialFits = remShift >= {1'b0, dvsr};
        trialDiff = remShift[W-1:0] - dvsr;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            prod <= '0;
            mcand <= '0;
            rem <= '0;
            quo <= '0;
            dvsr <= '0;
            fixMsb <= 1'b0;
            negQuo <= 1'b0;
            negRem <= 1'b0;
            opDiv <= 1'b0;
            divByZero <= 1'b0;
            done <= 1'b0;
            div_zero <= 1'b0;
            hi_out <= '0;
            lo_out <= '0;
        end else begin
            done <= 1'b0;
            div_zero <= 1'b0;
            if (state == IDLE) begin
                count <= '0;
                if (start_mult) begin
                    state <= RUN_M;
                    prod <= {{(W+1){1'b0}}, op_b, 1'b0};
                    mcand <= unsignedOp ? {1'b0, op_a} : {op_a[W-1], op_a};
                    fixMsb <= unsignedOp && op_b[W-1];
                    opDiv <= 1'b0;
                    divByZero <= 1'b0;
                end else if (start_div) begin
                    state <= op_b == '0 ? FIN : RUN_D;
                    rem <= '0;
                    quo <= absA;
                    dvsr <= absB;
                    negQuo <= !unsignedOp && (op_a[W-1] ^ op_b[W-1]);
                    negRem <= !unsignedOp && op_a[W-1];
                    opDiv <= 1'b1;
                    divByZero <= op_b == '0;
                end
            end else if (state == RUN_M || state == RUN_D) begin
                count <= count + 1'b1;
                state <= lastStep ? FIN : state;
                if (state == RUN_M)
                    prod <= {boothSum[W], boothSum, prod[W:1]};
                else begin
                    rem <= trialFits ? trialDiff : remShift[W-1:0];
                    quo <= {quo[W-2:0], trialFits};
                end
            end else begin
                state <= IDLE;
                done <= 1'b1;
                div_zero <= divByZero;
                // Unsigned multiply: Booth saw op_b as signed, so add back op_a * 2^W when its MSB was set.
                if (!divByZero) begin
                    hi_out <= opDiv ? (negRem ? -rem : rem) : prod[2*W:W+1] + (fixMsb ? mcand[W-1:0] : '0);
                    lo_out <= opDiv ? (negQuo ? -quo : quo) : prod[W:1];
                end
            end
        end
    end
endmodule

// File: tb/tb_mult_div_seq.sv
// tb_mult_div_seq: directed and random MULT/DIV traffic checked every cycle against a cycle-count/arithmetic model.
module tb_mult_div_seq;
    localparam int W = 32;
    logic clock = 1'b0, reset = 1'b1, start_mult = 1'b0, start_div = 1'b0;
    logic [W-1:0] op_a = '0, op_b = '0;
    logic busy, done, div_zero;
    logic [W-1:0] hi_out, lo_out;
    int tests = 0, fails = 0;
    int n, bn, dn;
    logic [31:0] corner [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};

    always #5 clock = ~clock;

    mult_div_seq dut (
        .clock(clock), .reset(reset), .start_mult(start_mult), .start_div(start_div),
`ifdef MULT_DIV_UNSIGNED_EN
        .op_unsigned(1'b0),
`endif
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .div_zero(div_zero),
        .hi_out(hi_out), .lo_out(lo_out));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] mulRef(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return 64'(p);
    endfunction

    function automatic logic [63:0] divRef(input logic [31:0] a, input logic [31:0] b);
        longint q, r;
        q = longint'($signed(a)) / longint'($signed(b));
        r = longint'($signed(a)) % longint'($signed(b));
        return {r[31:0], q[31:0]};
    endfunction

    function automatic logic [31:0] pick();
        return $urandom_range(0, 3) == 0 ? corner[$urandom_range(0, 4)] : 32'($urandom);
    endfunction

    // Model: an accepted op completes W+1 edges later (1 edge for divide by zero); busy while more than one edge remains.
    int left = 0;
    logic [63:0] pend = '0;
    logic pendDz = 1'b0, expBusy = 1'b0, expDone = 1'b0, expDz = 1'b0;
    logic [31:0] expHi = '0, expLo = '0;
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            left = 0; expBusy = 0; expDone = 0; expDz = 0; expHi = 0; expLo = 0;
        end else begin
            expDone = 0;
            expDz = 0;
            if (left == 0) begin
                if (start_mult) begin
                    pend = mulRef(op_a, op_b); pendDz = 0; left = W + 1;
                end else if (start_div) begin
                    pendDz = op_b == 0;
                    pend = pendDz ? 64'd0 : divRef(op_a, op_b);
                    left = pendDz ? 1 : W + 1;
                end
            end else begin
                left--;
                if (left == 0) begin
                    expDone = 1;
                    expDz = pendDz;
                    if (!pendDz) {expHi, expLo} = pend;
                end
            end
            expBusy = left > 1;
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            chk("busy", busy, expBusy);
            chk("done", done, expDone);
            chk("div_zero", div_zero, expDz);
            chk("hi_out", hi_out, expHi);
            chk("lo_out", lo_out, expLo);
        end
    end

    task automatic startOp(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        start_mult = m; start_div = d; op_a = a; op_b = b;
        @(negedge clock);
        start_mult = 0; start_div = 0; op_a = $urandom; op_b = $urandom;
    endtask

    task automatic waitDone(input int glitchAt, output int cyc, output int busyN);
        cyc = 0;
        busyN = int'(busy);
        while (!done && cyc < 100) begin
            @(negedge clock);
            cyc++;
            start_div = cyc == glitchAt;
            if (cyc == glitchAt) begin op_a = $urandom; op_b = $urandom | 1; end
            if (!done) busyN += int'(busy);
        end
    endtask

    initial begin
        repeat (3) @(negedge clock);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset div_zero", div_zero, 0);
        chk("reset hi", hi_out, 0);
        chk("reset lo", lo_out, 0);
        reset = 0;

        startOp(1, 0, 32'd7, 32'hFFFFFFFD);
        waitDone(-1, n, bn);
        chk("t1 latency", n, W + 1);
        chk("t1 busy cycles", bn, W);
        chk("t1 busy at done", busy, 0);
        chk("t1 hi", hi_out, 32'hFFFFFFFF);
        chk("t1 lo", lo_out, 32'hFFFFFFEB);
        chk("t1 div_zero", div_zero, 0);

        startOp(1, 0, 32'h80000000, 32'h80000000);
        waitDone(-1, n, bn);
        chk("t2 hi", hi_out, 32'h40000000);
        chk("t2 lo", lo_out, 32'h00000000);

        startOp(0, 1, 32'hFFFFFFF9, 32'd2);
        waitDone(-1, n, bn);
        chk("t3 latency", n, W + 1);
        chk("t3 lo", lo_out, 32'hFFFFFFFD);
        chk("t3 hi", hi_out, 32'hFFFFFFFF);

        startOp(0, 1, 32'd5, 32'd0);
        waitDone(-1, n, bn);
        chk("t4 latency", n, 1);
        chk("t4 busy cycles", bn, 0);
        chk("t4 div_zero", div_zero, 1);
        chk("t4 hi kept", hi_out, 32'hFFFFFFFF);
        chk("t4 lo kept", lo_out, 32'hFFFFFFFD);
        @(negedge clock);
        chk("t4 done pulse", done, 0);
        chk("t4 div_zero pulse", div_zero, 0);

        startOp(0, 1, 32'h80000000, 32'hFFFFFFFF);
        waitDone(-1, n, bn);
        chk("t5 lo", lo_out, 32'h80000000);
        chk("t5 hi", hi_out, 32'h0);
        startOp(1, 1, 32'd6, 32'd7);
        waitDone(-1, n, bn);
        chk("t5 both lo", lo_out, 32'd42);
        chk("t5 both hi", hi_out, 32'd0);
        chk("t5 both div_zero", div_zero, 0);

        startOp(1, 0, 32'd3, 32'd4);
        waitDone(4, n, bn);
        chk("t6 latency", n, W + 1);
        chk("t6 lo", lo_out, 32'd12);
        dn = 0;
        repeat (40) begin @(negedge clock); dn += int'(done); end
        chk("t6 extra done", dn, 0);

        startOp(1, 0, $urandom | 1, $urandom | 1);
        repeat (9) @(negedge clock);
        #2 reset = 1;
        #1;
        chk("abort busy", busy, 0);
        chk("abort hi", hi_out, 0);
        chk("abort lo", lo_out, 0);
        chk("abort done", done, 0);
        repeat (2) @(negedge clock);
        reset = 0;
        dn = 0;
        repeat (40) begin @(negedge clock); dn += int'(done); end
        chk("abort no done", dn, 0);

        repeat (6000) begin
            @(negedge clock);
            start_mult = $urandom_range(0, 15) == 0;
            start_div = $urandom_range(0, 15) == 0;
            op_a = pick();
            op_b = $urandom_range(0, 7) == 0 ? 32'd0 : pick();
        end
        @(negedge clock);
        start_mult = 0; start_div = 0;
        repeat (40) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mult_div_seq.md
Name: mult_div_seq

Overview:
- Multicycle sequencer for the MULT/DIV instructions of the multicycle CPU.
- Accepts a one-cycle start from the main control FSM with operands from registers A and B.
- Iterates a Booth radix-2 multiply or a restoring divide, one step per clock, then loads the HI/LO registers.
- Reports completion, and divide-by-zero, back to the control FSM so it can leave its wait state or enter the exception sequence.

Parameters:
- W, 32, operand width; the product/remainder datapath is 2*W wide.
- CNT_W, 6, iteration counter width; must hold the value W.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start_mult  input  1  single-cycle request: signed multiply op_a*op_b.
- start_div  input  1  single-cycle request: signed divide op_a/op_b.
- op_a  input  W  multiplicand / dividend (from register A).
- op_b  input  W  multiplier / divisor (from register B).
- busy  output  1  high while an operation is in progress (states RUN_M, RUN_D).
- done  output  1  one-cycle pulse; hi_out/lo_out are valid in that cycle.
- div_zero  output  1  one-cycle pulse together with done when the divisor is 0.
- hi_out  output  W  HI register.
- lo_out  output  W  LO register.

Behaviour:
- Reset (asynchronous): state=IDLE, busy=0, done=0, div_zero=0, hi_out=0, lo_out=0, counter=0. Reset mid-operation aborts the operation; no done is produced.
- States and transitions:
  - IDLE → RUN_M on start_mult.
  - IDLE → RUN_D on start_div with op_b≠0.
  - IDLE → FIN on start_div with op_b=0.
  - RUN_M / RUN_D → FIN when counter reaches W.
  - FIN → IDLE unconditionally.
- Start sampling:
  - Starts are sampled only in IDLE. Starts during RUN_M, RUN_D or FIN are ignored; there is no queueing.
  - start_mult and start_div high together: multiply wins, divide is dropped.
- Operand capture: operands are latched into internal working registers at the start edge E0. op_a/op_b may change afterwards.
- Multiply (Booth radix-2):
  - Working regs: accumulator P[2W:0] = {W'b0, op_b, 1'b0}; multiplicand M = op_a.
  - Each edge examines P[1:0]:
    - 01: add M to the upper half.
    - 10: subtract M from the upper half.
  - Then arithmetic right shift of P by 1 and counter+1.
  - Result is the signed 2W-bit product: HI = upper W bits, LO = lower W bits.
- Divide (restoring, on magnitudes):
  - Each edge: shift the remainder:quotient pair left by 1, trial-subtract |divisor|, restore if negative, set the quotient bit.
  - Sign fix-up is applied on the FIN load:
    - Quotient is truncated toward zero and negated if the operand signs differ.
    - Remainder takes the sign of the dividend.
  - LO = quotient, HI = remainder.
  - 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (wraps, no overflow flag).
- Latency (start sampled at edge E0):
  - MULT/DIV: iterations on E1..EW; state FIN after EW.
  - FIN edge E(W+1): hi_out/lo_out load, done=1 from E(W+1) to E(W+2).
  - Total: done rises at E0+W+1 = E0+33 for W=32.
- Divide by zero:
  - E0 enters FIN directly.
  - At E1: done=1 and div_zero=1 for one cycle; hi_out/lo_out are NOT written and keep their previous values.
- busy is high exactly from E0 to the FIN edge; busy=0 in the cycle where done=1.
- hi_out/lo_out change only at a FIN edge of a successful operation (or on reset). They hold their values otherwise, including during RUN.

Optional Feature:
- Macro MULT_DIV_UNSIGNED_EN.
- Defined:
  - Adds input port op_unsigned (1 bit), sampled with start.
  - When op_unsigned=1: MULTU uses zero-extended operands (extra guard bit so Booth stays correct for bit 31 set); DIVU skips magnitude conversion and sign fix-up.
  - Latency is unchanged.
- Undefined: no op_unsigned port; all operations are signed.

Test Plan:
1. start_mult, op_a=7, op_b=0xFFFFFFFD (-3) → done at E0+33; HI=0xFFFFFFFF, LO=0xFFFFFFEB; busy high E0..E32.
2. start_mult, op_a=op_b=0x80000000 → HI=0x40000000, LO=0x00000000.
3. start_div, op_a=0xFFFFFFF9 (-7), op_b=2 → LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); done at E0+33.
4. Load HI/LO with a prior result, then start_div op_a=5, op_b=0 → done=div_zero=1 at E0+1 only; HI/LO unchanged; busy never high.
5. start_div op_a=0x80000000, op_b=0xFFFFFFFF → LO=0x80000000, HI=0. Also: start_mult and start_div asserted together → multiply result produced.
6. start_mult 3*4, then pulse start_div at E0+5 → ignored; single done at E0+33 with LO=12. Then a new op with reset asserted at E0+10 → busy, HI, LO =0 immediately; no done pulse.
